// File: rtl/mvm_pkg.sv
// Shared types and default sizing for the MVM lane sequencer.
// Holds the controller state encoding and a width helper for degenerate sizes.
package mvm_pkg;

    localparam int MVM_N        = 8;
    localparam int MVM_LANES    = 4;
    localparam int MVM_MULT_LAT = 7;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        LOAD_X,
        ISSUE,
        DRAIN,
        SEND
    } state_t;

    // Width of a counter/address that must hold 0..v-1, never narrower than one bit.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/mvm_lane_control_if.sv
// Load stream, bank strobes/addresses and result handshake of the MVM sequencer.
// master = controller side, slave = datapath/environment side.
interface mvm_lane_control_if
    import mvm_pkg::*;
#(
    parameter int N     = MVM_N,
    parameter int LANES = MVM_LANES
) ();

    localparam int AW_W = clog2_min1(N * N / LANES);
    localparam int AW_X = clog2_min1(N);
    localparam int GW   = clog2_min1(N / LANES);

    logic             input_valid;
    logic             input_ready;
    logic             new_matrix;
    logic [LANES-1:0] wr_en_w;
    logic [AW_W-1:0]  addr_w;
    logic             wr_en_x;
    logic [AW_X-1:0]  addr_x;
    logic             en_acc;
    logic             clear_acc;
    logic             output_valid;
    logic             output_ready;
    logic [GW-1:0]    out_group;
    logic [15:0]      stall_cycles;

    modport master (
        input  input_valid, new_matrix, output_ready,
        output input_ready, wr_en_w, addr_w, wr_en_x, addr_x,
        output en_acc, clear_acc, output_valid, out_group, stall_cycles
    );

    modport slave (
        output input_valid, new_matrix, output_ready,
        input  input_ready, wr_en_w, addr_w, wr_en_x, addr_x,
        input  en_acc, clear_acc, output_valid, out_group, stall_cycles
    );

endinterface

// File: rtl/mvm_lat_shift.sv
// 1-bit valid delay line, DEPTH cycles from d_i to q_o.
// No backpressure: shifts every cycle; rst_n clears all stages asynchronously.
module mvm_lat_shift #(
    parameter int DEPTH = 7
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [DEPTH-1:0] sh_q;
    logic [DEPTH-1:0] sh_d;

    generate
        if (DEPTH == 1) begin : g_one
            assign sh_d = d_i;
        end else begin : g_many
            assign sh_d = {sh_q[DEPTH-2:0], d_i};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

    assign q_o = sh_q[DEPTH-1];

endmodule

// File: rtl/mvm_lane_control.sv
// Sequencer for the LANES-wide pipelined MVM: loads W/x, issues column beats, returns row groups.
// Group latency N+MULT_LAT cycles from ISSUE; strobes/addresses combinational with the transfer.
// Holds output_valid until output_ready; optional stall counter under MVM_STALL_CNT_EN.
module mvm_lane_control
    import mvm_pkg::*;
#(
    parameter int N        = MVM_N,
    parameter int LANES    = MVM_LANES,
    parameter int MULT_LAT = MVM_MULT_LAT
) (
    input logic               clk,
    input logic               rst_n,
    mvm_lane_control_if.master bus
);

    localparam int LOG2N      = $clog2(N);
    localparam int LOG2L      = $clog2(LANES);
    localparam int CW         = clog2_min1(N * N);
    localparam int AW_W       = clog2_min1(N * N / LANES);
    localparam int AW_X       = clog2_min1(N);
    localparam int GW         = clog2_min1(N / LANES);
    localparam int DW         = clog2_min1(MULT_LAT);
    localparam int LAST_GROUP = N / LANES - 1;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW_X-1:0] col_q, col_d;
    logic [GW-1:0]   group_q, group_d;
    logic [DW-1:0]   drain_q, drain_d;
    logic            w_loaded_q, w_loaded_d;

    logic             in_ready;
    logic [LANES-1:0] wr_en_w;
    logic [AW_W-1:0]  addr_w;
    logic             wr_en_x;
    logic [AW_X-1:0]  addr_x;
    logic             clear_acc;
    logic             out_valid;
    logic             beat;
    logic             en_acc;

    // Word k = r*N + c lands in bank r%LANES at (r/LANES)*N + c.
    logic [LANES-1:0] w_bank_oh;
    logic [AW_W-1:0]  w_addr;
    logic [AW_W-1:0]  issue_addr;

    assign w_bank_oh  = LANES'(1) << ((cnt_q >> LOG2N) & CW'(LANES - 1));
    assign w_addr     = AW_W'(((cnt_q >> (LOG2N + LOG2L)) << LOG2N) | (cnt_q & CW'(N - 1)));
    assign issue_addr = AW_W'((CW'(group_q) << LOG2N) | CW'(col_q));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        col_d      = col_q;
        group_d    = group_q;
        drain_d    = drain_q;
        w_loaded_d = w_loaded_q;
        in_ready   = 1'b0;
        wr_en_w    = '0;
        addr_w     = '0;
        wr_en_x    = 1'b0;
        addr_x     = '0;
        clear_acc  = 1'b0;
        out_valid  = 1'b0;
        beat       = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready  = 1'b1;
                clear_acc = 1'b1;
                if (bus.input_valid) begin
                    if (bus.new_matrix) begin
                        wr_en_w = w_bank_oh;
                        addr_w  = w_addr;
                        cnt_d   = cnt_q + CW'(1);
                        state_d = LOAD_W;
                    end else if (w_loaded_q) begin
                        wr_en_x = 1'b1;
                        addr_x  = AW_X'(cnt_q);
                        cnt_d   = cnt_q + CW'(1);
                        state_d = LOAD_X;
                    end
                end
            end
            LOAD_W: begin
                in_ready = 1'b1;
                if (bus.input_valid) begin
                    wr_en_w = w_bank_oh;
                    addr_w  = w_addr;
                    if (cnt_q == CW'(N * N - 1)) begin
                        cnt_d      = '0;
                        w_loaded_d = 1'b1;
                        state_d    = LOAD_X;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            LOAD_X: begin
                in_ready = 1'b1;
                if (bus.input_valid) begin
                    wr_en_x = 1'b1;
                    addr_x  = AW_X'(cnt_q);
                    if (cnt_q == CW'(N - 1)) begin
                        cnt_d   = '0;
                        col_d   = '0;
                        group_d = '0;
                        state_d = ISSUE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            ISSUE: begin
                beat   = 1'b1;
                addr_w = issue_addr;
                addr_x = col_q;
                if (col_q == AW_X'(N - 1)) begin
                    col_d   = '0;
                    drain_d = '0;
                    state_d = DRAIN;
                end else begin
                    col_d = col_q + AW_X'(1);
                end
            end
            DRAIN: begin
                // The last beat reaches the accumulators in the final DRAIN cycle.
                if (drain_q == DW'(MULT_LAT - 1)) begin
                    drain_d = '0;
                    state_d = SEND;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            SEND: begin
                out_valid = 1'b1;
                if (bus.output_ready) begin
                    clear_acc = 1'b1;
                    if (group_q == GW'(LAST_GROUP)) begin
                        group_d = '0;
                        state_d = IDLE;
                    end else begin
                        group_d = group_q + GW'(1);
                        state_d = ISSUE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            col_q      <= '0;
            group_q    <= '0;
            drain_q    <= '0;
            w_loaded_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            col_q      <= col_d;
            group_q    <= group_d;
            drain_q    <= drain_d;
            w_loaded_q <= w_loaded_d;
        end
    end

    mvm_lat_shift #(
        .DEPTH(MULT_LAT)
    ) u_lat (
        .clk  (clk),
        .rst_n(rst_n),
        .d_i  (beat),
        .q_o  (en_acc)
    );

`ifdef MVM_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (out_valid && !bus.output_ready && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign bus.stall_cycles = stall_q;
`else
    assign bus.stall_cycles = '0;
`endif

    assign bus.input_ready  = in_ready;
    assign bus.wr_en_w      = wr_en_w;
    assign bus.addr_w       = addr_w;
    assign bus.wr_en_x      = wr_en_x;
    assign bus.addr_x       = addr_x;
    assign bus.en_acc       = en_acc;
    assign bus.clear_acc    = clear_acc;
    assign bus.output_valid = out_valid;
    assign bus.out_group    = group_q;

endmodule

// File: tb/tb_mvm_lane_control.sv
// Directed bench for mvm_lane_control (N=8, LANES=4, MULT_LAT=7).
// Vector table for reset/IDLE behaviour, hand-written sequences for load, compute, stall and reset abort.
module tb_mvm_lane_control;
    import mvm_pkg::*;

    localparam int N     = 8;
    localparam int LANES = 4;
    localparam int ML    = 7;
    localparam int NG    = N / LANES;
`ifdef MVM_STALL_CNT_EN
    localparam int EXP_STALL = 10;
`else
    localparam int EXP_STALL = 0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mvm_lane_control_if #(.N(N), .LANES(LANES)) bus ();

    mvm_lane_control #(
        .N       (N),
        .LANES   (LANES),
        .MULT_LAT(ML)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.master)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       rst_n;
        logic       iv;
        logic       nm;
        logic       ir;
        logic       clr;
        logic       ov;
        logic       wx;
        logic [3:0] ww;
        logic       en;
    } vec_t;

    vec_t vt[4];

    task automatic load_w(input bit gap);
        int k = 0;
        int pulses = 0;
        int cyc = 0;
        while (k < N * N && cyc < 400) begin
            if (gap && (cyc % 2 == 1)) begin
                bus.input_valid = 1'b0;
                #1;
                chk($sformatf("w_gap_wren c%0d", cyc), bus.wr_en_w, 0);
                if (bus.wr_en_w != 0) pulses++;
            end else begin
                bus.input_valid = 1'b1;
                bus.new_matrix  = 1'b1;
                #1;
                chk($sformatf("w_bank k%0d", k), bus.wr_en_w, 1 << ((k / N) % LANES));
                chk($sformatf("w_addr k%0d", k), bus.addr_w, (k / N / LANES) * N + k % N);
                chk($sformatf("w_no_xwr k%0d", k), bus.wr_en_x, 0);
                if (bus.wr_en_w != 0) pulses++;
                k++;
            end
            next_cyc();
            cyc++;
        end
        bus.input_valid = 1'b0;
        chk("w_pulses", pulses, N * N);
    endtask

    task automatic load_x();
        for (int c = 0; c < N; c++) begin
            bus.input_valid = 1'b1;
            bus.new_matrix  = 1'b0;
            #1;
            chk($sformatf("x_wren c%0d", c), bus.wr_en_x, 1);
            chk($sformatf("x_addr c%0d", c), bus.addr_x, c);
            chk($sformatf("x_no_wwr c%0d", c), bus.wr_en_w, 0);
            chk($sformatf("x_ready c%0d", c), bus.input_ready, 1);
            next_cyc();
        end
        bus.input_valid = 1'b0;
    endtask

    task automatic compute(input int stall0);
        for (int g = 0; g < NG; g++) begin
            int en_cnt = 0;
            bus.output_ready = 1'b1;
            for (int j = 0; j < N + ML; j++) begin
                #1;
                chk($sformatf("en_acc g%0d j%0d", g, j), bus.en_acc, (j >= ML) ? 1 : 0);
                chk($sformatf("ov_early g%0d j%0d", g, j), bus.output_valid, 0);
                if (j == 0) chk($sformatf("busy_ready g%0d", g), bus.input_ready, 0);
                if (j < N) begin
                    chk($sformatf("iss_addr_w g%0d j%0d", g, j), bus.addr_w, g * N + j);
                    chk($sformatf("iss_addr_x g%0d j%0d", g, j), bus.addr_x, j);
                end
                if (bus.en_acc === 1'b1) en_cnt++;
                next_cyc();
            end
            chk($sformatf("en_count g%0d", g), en_cnt, N);
            if (g == 0) begin
                bus.output_ready = 1'b0;
                for (int s = 0; s < stall0; s++) begin
                    #1;
                    chk($sformatf("stall_ov s%0d", s), bus.output_valid, 1);
                    chk($sformatf("stall_grp s%0d", s), bus.out_group, g);
                    chk($sformatf("stall_clr s%0d", s), bus.clear_acc, 0);
                    next_cyc();
                end
            end
            bus.output_ready = 1'b1;
            #1;
            chk($sformatf("send_ov g%0d", g), bus.output_valid, 1);
            chk($sformatf("send_grp g%0d", g), bus.out_group, g);
            chk($sformatf("send_clr g%0d", g), bus.clear_acc, 1);
            next_cyc();
        end
        #1;
        chk("done_idle_ready", bus.input_ready, 1);
        chk("done_idle_clr", bus.clear_acc, 1);
        chk("done_ov", bus.output_valid, 0);
    endtask

    initial begin
        rst_n            = 1'b0;
        bus.input_valid  = 1'b0;
        bus.new_matrix   = 1'b0;
        bus.output_ready = 1'b1;

        //            rst  iv  nm  ir  clr ov  wx  ww    en
        vt[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0};
        vt[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0};
        vt[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0};
        vt[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0};

        for (int i = 0; i < 4; i++) begin
            rst_n           = vt[i].rst_n;
            bus.input_valid = vt[i].iv;
            bus.new_matrix  = vt[i].nm;
            #1;
            chk($sformatf("vec%0d input_ready", i), bus.input_ready, vt[i].ir);
            chk($sformatf("vec%0d clear_acc", i), bus.clear_acc, vt[i].clr);
            chk($sformatf("vec%0d output_valid", i), bus.output_valid, vt[i].ov);
            chk($sformatf("vec%0d wr_en_x", i), bus.wr_en_x, vt[i].wx);
            chk($sformatf("vec%0d wr_en_w", i), bus.wr_en_w, vt[i].ww);
            chk($sformatf("vec%0d en_acc", i), bus.en_acc, vt[i].en);
            chk($sformatf("vec%0d addr_w", i), bus.addr_w, 0);
            chk($sformatf("vec%0d addr_x", i), bus.addr_x, 0);
            chk($sformatf("vec%0d out_group", i), bus.out_group, 0);
            chk($sformatf("vec%0d stall", i), bus.stall_cycles, 0);
            next_cyc();
        end

        // Full W + x job, no back-pressure.
        load_w(1'b0);
        load_x();
        compute(0);
        chk("stall_after_job1", bus.stall_cycles, 0);

        // x-only job reusing W, consumer stalls group 0 for 10 cycles.
        load_x();
        compute(10);
        chk("stall_after_job2", bus.stall_cycles, EXP_STALL);

        // W load with input_valid toggling every other cycle.
        load_w(1'b1);
        load_x();
        compute(0);

        // Reset in the middle of DRAIN aborts and forgets W.
        load_x();
        for (int j = 0; j < N + 2; j++) next_cyc();
        #1;
        chk("pre_rst_en_acc", bus.en_acc, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_en_acc", bus.en_acc, 0);
        chk("rst_ov", bus.output_valid, 0);
        chk("rst_ready", bus.input_ready, 1);
        chk("rst_clr", bus.clear_acc, 1);
        chk("rst_addr_w", bus.addr_w, 0);
        chk("rst_addr_x", bus.addr_x, 0);
        chk("rst_stall", bus.stall_cycles, 0);
        next_cyc();
        rst_n = 1'b1;
        next_cyc();
        for (int c = 0; c < N; c++) begin
            bus.input_valid = 1'b1;
            bus.new_matrix  = 1'b0;
            #1;
            chk($sformatf("post_rst_xwr c%0d", c), bus.wr_en_x, 0);
            chk($sformatf("post_rst_ready c%0d", c), bus.input_ready, 1);
            next_cyc();
        end
        bus.input_valid = 1'b0;
        #1;
        chk("post_rst_idle_clr", bus.clear_acc, 1);
        chk("post_rst_no_issue", bus.en_acc, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
